led_sequencer: RTL and testbench
================================

# led_sequencer

Programmable LED pattern controller that drives the board LED through a stored sequence of on/off steps, each lasting a whole number of fixed ticks derived from the system clock frequency. It sits between the top level and the LED pin. It is a richer counterpart to the fixed-rate blinker: host logic loads steps, starts the sequence and observes progress.

## Interface

**Parameters**
- `FREQ`, default 0: clock frequency in Hz. Must be ≥ `TICK_HZ`, otherwise an `initial` check calls `$fatal`.
- `TICK_HZ`, default 10: tick rate. Tick period is `TICK_CYC = FREQ/TICK_HZ` clock cycles (integer division).
- `STEPS`, default 8: number of pattern entries, 2..16. Address width is `AW = $clog2(STEPS)`.
- `DW`, default 8: step duration width, in ticks.

**Ports**
- `clk_i`, input, 1: the only clock.
- `rst_i`, input, 1: reset, synchronous and active-high.
- `wr_i`, input, 1: write strobe for a pattern entry.
- `waddr_i`, input, AW: entry index. Writes with `waddr_i ≥ STEPS` are ignored.
- `wlevel_i`, input, 1: LED level for the entry.
- `wdur_i`, input, DW: duration of the entry, in ticks.
- `start_i`, input, 1: start request.
- `len_i`, input, AW+1: number of active steps, sampled on start.
- `loop_i`, input, 1: 1 = repeat forever, 0 = one-shot. Sampled on start.
- `stop_i`, input, 1: abort.
- `led_o`, output, 1: LED drive.
- `busy_o`, output, 1: sequence running.
- `done_o`, output, 1: one-cycle pulse at the end of a one-shot sequence.
- `step_o`, output, AW: index of the current step.

## Operation

**Pattern memory.** The memory is an array of `STEPS` registers of `{level, dur}`. It is written on `clk_i` when `wr_i` is high, with or without `busy_o`. Reads are combinational. The running step uses values latched at step entry, so a write affects a step only the next time that step is entered.

**State machine** with states IDLE, RUN, DONE.
- IDLE: `start_i=1`, `stop_i=0` and `1 ≤ len_i ≤ STEPS` → RUN.
  - Latch `len_i` and `loop_i`.
  - Enter step 0 and clear the tick prescaler.
  - Any other `len_i` value: the start is ignored and the state stays IDLE.
- RUN, step entry k: latch `level[k]` and `dur[k]` and set `step_o=k`.
  - If `dur[k]=0`: the step consumes exactly 1 cycle, `led_o` keeps its previous value, and step k+1 is entered next.
  - Otherwise `led_o=level[k]` is held for exactly `dur[k]*TICK_CYC` cycles.
- RUN, last step (k = len−1) ends:
  - `loop=1`: enter step 0 on the next cycle with no gap.
  - `loop=0`: go to DONE.
- DONE: lasts one cycle with `done_o=1`, `led_o=0`, `busy_o=0`, then IDLE.
- `stop_i=1` in RUN or DONE → IDLE on the next cycle, with `led_o=0` and no `done_o`. If `stop_i` and `start_i` are asserted together, stop wins.
- `start_i` while in RUN is ignored; there is no restart.

**Arithmetic.**
- The tick prescaler counts 0..`TICK_CYC`−1.
- The duration counter counts ticks, 0..`dur`−1.
- Both counters are unsigned and wrap only under these rules.
- `len_i` values above `STEPS` are treated as invalid (start ignored, as above).

## Timing

**Reset** (synchronous, takes effect on the `clk_i` edge with `rst_i=1`):
- `led_o=0`, `busy_o=0`, `done_o=0`, `step_o=0`, state IDLE.
- All memory entries cleared to `{0,0}`; prescaler and counters cleared.
- Reset mid-sequence aborts immediately with no `done_o`.

**Start latency.** With `start_i` sampled at edge t, the following hold from cycle t+1:
- `busy_o=1`, `step_o=0`.
- `led_o=level[0]` (for nonzero `dur[0]`).

**Step boundary.** Step k+1 begins exactly `dur[k]*TICK_CYC` cycles after step k began. Zero-duration steps add 1 cycle each.

**End of one-shot.**
- `done_o` is high during the first cycle after the last step expires.
- `busy_o` falls in that same cycle.

**Stop latency.** With `stop_i` sampled at edge t, from cycle t+1: `led_o=0`, `busy_o=0`, `step_o=0`.

## Structure

- Shared header/package `led_seq_pkg`:
  - State encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Entry field widths.
  - Default `TICK_HZ`.
- Sub-module `tick_gen` (parameters `FREQ`, `TICK_HZ`; ports `clk_i`, `rst_i`, `clr_i`, `tick_o`):
  - Prescaler that produces a one-cycle `tick_o` every `TICK_CYC` cycles.
  - Synchronously cleared by `clr_i` at every step entry.
- Top-level glue contains the memory, FSM and step/duration counters.

## Test plan

All scenarios use `FREQ=40` and `TICK_HZ=10`, so `TICK_CYC=4`.

1. Reset check: assert `rst_i` for 2 cycles → all outputs 0. Read back via a run: all-zero memory with `len=1` runs a 1-cycle step, then `done_o`.
2. One-shot: load {1,2},{0,1},{1,3}, `len=3`, `loop=0`, start at t.
   - `led_o`: 1 for 8 cycles, 0 for 4 cycles, 1 for 12 cycles.
   - `done_o` pulses at t+25.
   - `busy_o` is high from t+1 to t+24.
3. Loop and stop: same pattern with `loop=1`.
   - Step 0 re-entered at t+25 with no gap.
   - `stop_i` at t+30 → `led_o=0`, `busy_o=0` at t+31, no `done_o`.
4. Zero durations: entries {1,1},{0,0},{0,0},{1,1}, `len=4`.
   - `led_o` stays 1 for 4+2 cycles, then holds 1 for the last 4 cycles.
   - `done_o` at t+11.
5. Boundary commands:
   - `len_i=0` and `len_i=STEPS+1` → no start.
   - `start_i`+`stop_i` together → stays IDLE.
   - `start_i` during RUN → ignored.
   - Write to step 0 during step 1 → new value used on the next loop pass.
6. Reset mid-run: `rst_i` during step 1 → next cycle all outputs 0 and memory cleared.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: FSM encoding,
// pattern entry field widths and default tick rate.
package led_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int LEVEL_W         = 1;
  localparam int DUR_W_DEFAULT   = 8;
  localparam int TICK_HZ_DEFAULT = 10;

endpackage

// File: rtl/led_sequencer_tick_gen.sv
// Prescaler emitting a one-cycle tick every FREQ/TICK_HZ clock cycles,
// restartable so each pattern step begins on a fresh tick period.
module tick_gen
  import led_seq_pkg::*;
#(
  parameter int FREQ    = 0,
  parameter int TICK_HZ = TICK_HZ_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int TICK_CYC = FREQ / TICK_HZ;
  // Guard against a zero period so the counter width stays legal.
  localparam int CYC = (TICK_CYC < 1) ? 1 : TICK_CYC;
  localparam int CW  = (CYC > 1) ? $clog2(CYC) : 1;

  logic [CW-1:0] cnt_reg;

  assign tick_o = (cnt_reg == CW'(CYC - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_reg <= '0;
    end else if (tick_o) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// Programmable LED sequencer: pattern memory, run/done FSM and per-step
// duration counting on top of the shared tick prescaler.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int FREQ    = 0,
  parameter int TICK_HZ = TICK_HZ_DEFAULT,
  parameter int STEPS   = 8,
  parameter int DW      = DUR_W_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_i,
  input  logic [$clog2(STEPS)-1:0]   waddr_i,
  input  logic                       wlevel_i,
  input  logic [DW-1:0]              wdur_i,
  input  logic                       start_i,
  input  logic [$clog2(STEPS):0]     len_i,
  input  logic                       loop_i,
  input  logic                       stop_i,
  output logic                       led_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [$clog2(STEPS)-1:0]   step_o
);

  localparam int AW = $clog2(STEPS);
  localparam logic [AW:0] LEN_MAX = (AW + 1)'(STEPS);
  localparam logic [AW:0] LEN_ONE = (AW + 1)'(1);

  if (FREQ < TICK_HZ) begin : g_freq_check
    $fatal(1, "led_sequencer: FREQ must be at least TICK_HZ");
  end
  if (STEPS < 2 || STEPS > 16) begin : g_steps_check
    $fatal(1, "led_sequencer: STEPS must be within 2..16");
  end

  logic [LEVEL_W-1:0] mem_level [STEPS];
  logic [DW-1:0]      mem_dur   [STEPS];

  state_t        state_reg, state_next;
  logic          led_reg;
  logic [AW-1:0] step_reg;
  logic [DW-1:0] dur_reg;
  logic [DW-1:0] dur_cnt_reg;
  logic [AW:0]   len_reg;
  logic          loop_reg;

  logic          tick;
  logic          enter;
  logic [AW-1:0] enter_idx;
  logic          len_ok;
  logic          step_end;
  logic          last_step;

  // Each entry owns its registers; out-of-range addresses match no entry.
  for (genvar gi = 0; gi < STEPS; gi++) begin : g_mem
    logic [LEVEL_W-1:0] level_reg;
    logic [DW-1:0]      dur_reg;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        level_reg <= '0;
        dur_reg   <= '0;
      end else if (wr_i && waddr_i == AW'(gi)) begin
        level_reg <= wlevel_i;
        dur_reg   <= wdur_i;
      end
    end

    assign mem_level[gi] = level_reg;
    assign mem_dur[gi]   = dur_reg;
  end

  tick_gen #(
    .FREQ    (FREQ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (enter),
    .tick_o (tick)
  );

  assign len_ok    = (len_i != '0) && (len_i <= LEN_MAX);
  // A zero-duration step always ends after its single entry cycle.
  assign step_end  = (dur_reg == '0) || (tick && dur_cnt_reg == dur_reg - DW'(1));
  assign last_step = ({1'b0, step_reg} == len_reg - LEN_ONE);

  always_comb begin
    state_next = state_reg;
    enter      = 1'b0;
    enter_idx  = '0;
    case (state_reg)
      ST_IDLE: begin
        if (start_i && !stop_i && len_ok) begin
          state_next = ST_RUN;
          enter      = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          state_next = ST_IDLE;
        end else if (step_end) begin
          if (!last_step) begin
            enter     = 1'b1;
            enter_idx = step_reg + AW'(1);
          end else if (loop_reg) begin
            enter = 1'b1;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      led_reg     <= 1'b0;
      step_reg    <= '0;
      dur_reg     <= '0;
      dur_cnt_reg <= '0;
      len_reg     <= '0;
      loop_reg    <= 1'b0;
    end else begin
      if (state_reg == ST_IDLE && state_next == ST_RUN) begin
        len_reg  <= len_i;
        loop_reg <= loop_i;
      end
      if (enter) begin
        step_reg    <= enter_idx;
        dur_reg     <= mem_dur[enter_idx];
        dur_cnt_reg <= '0;
        if (mem_dur[enter_idx] != '0) begin
          led_reg <= mem_level[enter_idx];
        end
      end else if (state_next != ST_RUN) begin
        led_reg     <= 1'b0;
        step_reg    <= '0;
        dur_cnt_reg <= '0;
      end else if (tick) begin
        dur_cnt_reg <= dur_cnt_reg + DW'(1);
      end
    end
  end

  assign led_o  = led_reg;
  assign busy_o = (state_reg == ST_RUN);
  assign done_o = (state_reg == ST_DONE);
  assign step_o = step_reg;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer at FREQ=40, TICK_HZ=10 (4-cycle tick);
// expected waveforms are hand-derived cycle tables.
module tb_led_sequencer;

  localparam int STEPS = 8;
  localparam int AW    = 3;
  localparam int DW    = 8;

  logic          clk_i = 1'b0;
  logic          rst_i, wr_i, wlevel_i, start_i, loop_i, stop_i;
  logic [AW-1:0] waddr_i;
  logic [DW-1:0] wdur_i;
  logic [AW:0]   len_i;
  logic          led_o, busy_o, done_o;
  logic [AW-1:0] step_o;

  int checks = 0;
  int errors = 0;

  led_sequencer #(
    .FREQ    (40),
    .TICK_HZ (10),
    .STEPS   (STEPS),
    .DW      (DW)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_i     (wr_i),
    .waddr_i  (waddr_i),
    .wlevel_i (wlevel_i),
    .wdur_i   (wdur_i),
    .start_i  (start_i),
    .len_i    (len_i),
    .loop_i   (loop_i),
    .stop_i   (stop_i),
    .led_o    (led_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .step_o   (step_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic l, input logic b,
                         input logic d, input logic [AW-1:0] s);
    chk({tag, ".led"}, 32'(led_o), 32'(l));
    chk({tag, ".busy"}, 32'(busy_o), 32'(b));
    chk({tag, ".done"}, 32'(done_o), 32'(d));
    chk({tag, ".step"}, 32'(step_o), 32'(s));
    $display("%0t %s led=%0b busy=%0b done=%0b step=%0d", $time, tag, led_o, busy_o, done_o, step_o);
  endtask

  task automatic wr_entry(input logic [AW-1:0] a, input logic lv, input logic [DW-1:0] d);
    wr_i = 1'b1; waddr_i = a; wlevel_i = lv; wdur_i = d;
    cyc();
    wr_i = 1'b0;
  endtask

  // Drives start for one edge; returns in the first cycle after that edge.
  task automatic launch(input logic [AW:0] len, input logic lp);
    len_i = len; loop_i = lp; start_i = 1'b1;
    cyc();
    start_i = 1'b0;
  endtask

  initial begin
    logic          el, eb, ed;
    logic [AW-1:0] es;

    rst_i = 1'b1; wr_i = 1'b0; waddr_i = '0; wlevel_i = 1'b0; wdur_i = '0;
    start_i = 1'b0; len_i = '0; loop_i = 1'b0; stop_i = 1'b0;
    cyc();
    cyc();
    chk_out("reset", 1'b0, 1'b0, 1'b0, 3'd0);
    rst_i = 1'b0;

    // Cleared memory, len=1: one 1-cycle step then done.
    launch(4'd1, 1'b0);
    chk_out("rstrun[1]", 1'b0, 1'b1, 1'b0, 3'd0);
    cyc();
    chk_out("rstrun[2]", 1'b0, 1'b0, 1'b1, 3'd0);
    cyc();
    chk_out("rstrun[3]", 1'b0, 1'b0, 1'b0, 3'd0);

    // One-shot {1,2},{0,1},{1,3}.
    wr_entry(3'd0, 1'b1, 8'd2);
    wr_entry(3'd1, 1'b0, 8'd1);
    wr_entry(3'd2, 1'b1, 8'd3);
    launch(4'd3, 1'b0);
    for (int n = 1; n <= 27; n++) begin
      if (n > 1) cyc();
      el = (n <= 8) || (n >= 13 && n <= 24);
      eb = (n <= 24);
      ed = (n == 25);
      es = (n <= 8) ? 3'd0 : (n <= 12) ? 3'd1 : (n <= 24) ? 3'd2 : 3'd0;
      chk_out($sformatf("oneshot[%0d]", n), el, eb, ed, es);
    end

    // Same pattern looping, stop sampled at edge t+30.
    launch(4'd3, 1'b1);
    for (int n = 1; n <= 30; n++) begin
      if (n > 1) cyc();
      el = (n <= 8) || (n >= 13);
      es = (n <= 8) ? 3'd0 : (n <= 12) ? 3'd1 : (n <= 24) ? 3'd2 : 3'd0;
      if (n == 8 || n == 9 || n == 24 || n == 25 || n == 30)
        chk_out($sformatf("loop[%0d]", n), el, 1'b1, 1'b0, es);
    end
    stop_i = 1'b1;
    cyc();
    stop_i = 1'b0;
    chk_out("loop.stop[31]", 1'b0, 1'b0, 1'b0, 3'd0);
    cyc();
    chk_out("loop.stop[32]", 1'b0, 1'b0, 1'b0, 3'd0);

    // Zero-duration steps {1,1},{0,0},{0,0},{1,1}.
    wr_entry(3'd0, 1'b1, 8'd1);
    wr_entry(3'd1, 1'b0, 8'd0);
    wr_entry(3'd2, 1'b0, 8'd0);
    wr_entry(3'd3, 1'b1, 8'd1);
    launch(4'd4, 1'b0);
    for (int n = 1; n <= 12; n++) begin
      if (n > 1) cyc();
      el = (n <= 10);
      eb = (n <= 10);
      ed = (n == 11);
      es = (n <= 4) ? 3'd0 : (n == 5) ? 3'd1 : (n == 6) ? 3'd2 : (n <= 10) ? 3'd3 : 3'd0;
      chk_out($sformatf("zero[%0d]", n), el, eb, ed, es);
    end

    // Invalid lengths and start+stop never leave IDLE.
    launch(4'd0, 1'b0);
    chk_out("len0", 1'b0, 1'b0, 1'b0, 3'd0);
    launch(4'd9, 1'b0);
    chk_out("len9", 1'b0, 1'b0, 1'b0, 3'd0);
    stop_i = 1'b1;
    launch(4'd3, 1'b0);
    stop_i = 1'b0;
    chk_out("startstop[1]", 1'b0, 1'b0, 1'b0, 3'd0);
    cyc();
    chk_out("startstop[2]", 1'b0, 1'b0, 1'b0, 3'd0);

    // Start during RUN ignored; step 0 rewritten to {0,1} while step 1 runs.
    wr_entry(3'd0, 1'b1, 8'd2);
    wr_entry(3'd1, 1'b0, 8'd1);
    wr_entry(3'd2, 1'b1, 8'd3);
    launch(4'd3, 1'b1);
    for (int n = 1; n <= 33; n++) begin
      if (n > 1) cyc();
      case (n)
        8:  chk_out("rerun[8]", 1'b1, 1'b1, 1'b0, 3'd0);
        9:  chk_out("rerun[9]", 1'b0, 1'b1, 1'b0, 3'd1);
        13: chk_out("rerun[13]", 1'b1, 1'b1, 1'b0, 3'd2);
        24: chk_out("rerun[24]", 1'b1, 1'b1, 1'b0, 3'd2);
        25: chk_out("rerun[25]", 1'b0, 1'b1, 1'b0, 3'd0);
        28: chk_out("rerun[28]", 1'b0, 1'b1, 1'b0, 3'd0);
        29: chk_out("rerun[29]", 1'b0, 1'b1, 1'b0, 3'd1);
        33: chk_out("rerun[33]", 1'b1, 1'b1, 1'b0, 3'd2);
        default: ;
      endcase
      if (n == 3) start_i = 1'b1;
      if (n == 4) start_i = 1'b0;
      if (n == 9) begin
        wr_i = 1'b1; waddr_i = 3'd0; wlevel_i = 1'b0; wdur_i = 8'd1;
      end
      if (n == 10) wr_i = 1'b0;
    end
    stop_i = 1'b1;
    cyc();
    stop_i = 1'b0;
    chk_out("rerun.stop", 1'b0, 1'b0, 1'b0, 3'd0);

    // Reset during step 1 aborts and clears memory.
    wr_entry(3'd0, 1'b1, 8'd2);
    launch(4'd3, 1'b1);
    for (int n = 2; n <= 10; n++) cyc();
    chk_out("midrst.pre", 1'b0, 1'b1, 1'b0, 3'd1);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    chk_out("midrst.post", 1'b0, 1'b0, 1'b0, 3'd0);
    launch(4'd3, 1'b0);
    for (int n = 1; n <= 4; n++) begin
      if (n > 1) cyc();
      eb = (n <= 3);
      ed = (n == 4);
      es = (n <= 3) ? 3'(n - 1) : 3'd0;
      chk_out($sformatf("cleared[%0d]", n), 1'b0, eb, ed, es);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
